// File: rtl/devil_snoop_sched.sv
// Snoop response scheduler: accepts one AC snoop at a time and answers it on CR,
// optionally delaying and forcing crresp for snoops selected by address/type filters.
module devil_snoop_sched (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cfg_en,
   input  logic        cfg_func,
   input  logic        cfg_acflt,
   input  logic        cfg_addrflt,
   input  logic [3:0]  cfg_acsnoop,
   input  logic [31:0] cfg_base,
   input  logic [31:0] cfg_size,
   input  logic [31:0] cfg_delay,
   input  logic [4:0]  cfg_crresp,
   input  logic        status_clr,
   input  logic        acvalid,
   output logic        acready,
   input  logic [43:0] acaddr,
   input  logic [3:0]  acsnoop,
   output logic        crvalid,
   input  logic        crready,
   output logic [4:0]  crresp,
   output logic        status_done,
   output logic [31:0] hit_count,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic        attacked;

   logic [32:0] lim;
   logic        addr_hit;
   logic        ac_hit;
   logic        match;
   logic        attack;
   logic        ac_hs;
   logic        cr_hs;
   logic        unused_addr;

   // Upper address bits play no part in the window compare.
   assign unused_addr = ^acaddr[43:32];

   always_comb begin
      lim      = {1'b0, cfg_base} + {1'b0, cfg_size};
      addr_hit = (cfg_size != 32'd0) &&
                 (cfg_base <= acaddr[31:0]) &&
                 ({1'b0, acaddr[31:0]} < lim);
      ac_hit   = (acsnoop == cfg_acsnoop);
      match    = (!cfg_addrflt || addr_hit) && (!cfg_acflt || ac_hit);
      attack   = cfg_en && match && (cfg_func || !status_done);
   end

   assign acready = (state == IDLE);
   assign crvalid = (state == RESP);
   assign busy    = (state != IDLE);
   assign ac_hs   = acvalid && acready;
   assign cr_hs   = crvalid && crready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= 32'd0;
         attacked    <= 1'b0;
         crresp      <= 5'd0;
         status_done <= 1'b0;
         hit_count   <= 32'd0;
      end else begin
         if (status_clr) begin
            status_done <= 1'b0;
            hit_count   <= 32'd0;
         end
         unique case (state)
            IDLE: begin
               if (ac_hs) begin
                  attacked <= attack;
                  if (!attack) begin
                     crresp <= 5'd0;
                     state  <= RESP;
                  end else if (cfg_delay == 32'd0) begin
                     crresp <= cfg_crresp;
                     state  <= RESP;
                  end else begin
                     crresp <= cfg_crresp;
                     cnt    <= cfg_delay;
                     state  <= DELAY;
                  end
               end
            end
            DELAY: begin
               cnt <= cnt - 32'd1;
               if (cnt == 32'd1)
                  state <= RESP;
            end
            RESP: begin
               if (cr_hs) begin
                  state    <= IDLE;
                  crresp   <= 5'd0;
                  attacked <= 1'b0;
                  // A completing attack outranks a coincident clear.
                  if (attacked) begin
                     status_done <= 1'b1;
                     if (status_clr)
                        hit_count <= 32'd1;
                     else if (hit_count != 32'hFFFF_FFFF)
                        hit_count <= hit_count + 32'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_devil_snoop_sched.sv
// Directed bench for devil_snoop_sched: latency, crresp,
// filters, stall, reset abandon and status bookkeeping.
module tb_devil_snoop_sched;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cfg_en;
   logic        cfg_func;
   logic        cfg_acflt;
   logic        cfg_addrflt;
   logic [3:0]  cfg_acsnoop;
   logic [31:0] cfg_base;
   logic [31:0] cfg_size;
   logic [31:0] cfg_delay;
   logic [4:0]  cfg_crresp;
   logic        status_clr;
   logic        acvalid;
   logic        acready;
   logic [43:0] acaddr;
   logic [3:0]  acsnoop;
   logic        crvalid;
   logic        crready;
   logic [4:0]  crresp;
   logic        status_done;
   logic [31:0] hit_count;
   logic        busy;

   int tests = 0;
   int fails = 0;

   devil_snoop_sched dut (
      .clk         (clk),
      .resetn      (resetn),
      .cfg_en      (cfg_en),
      .cfg_func    (cfg_func),
      .cfg_acflt   (cfg_acflt),
      .cfg_addrflt (cfg_addrflt),
      .cfg_acsnoop (cfg_acsnoop),
      .cfg_base    (cfg_base),
      .cfg_size    (cfg_size),
      .cfg_delay   (cfg_delay),
      .cfg_crresp  (cfg_crresp),
      .status_clr  (status_clr),
      .acvalid     (acvalid),
      .acready     (acready),
      .acaddr      (acaddr),
      .acsnoop     (acsnoop),
      .crvalid     (crvalid),
      .crready     (crready),
      .crresp      (crresp),
      .status_done (status_done),
      .hit_count   (hit_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snoop(input string nm, input logic [43:0] a,
                        input logic [3:0] s, input int lat,
                        input logic [4:0] rsp, input bit drop_en);
      int n;
      acaddr  = a;
      acsnoop = s;
      acvalid = 1'b1;
      tick();
      acvalid = 1'b0;
      if (drop_en) begin
         cfg_en     = 1'b0;
         cfg_crresp = 5'h00;
         cfg_delay  = 32'd9;
      end
      tests++;
      if (acready !== 1'b0) begin
         fails++;
         $display("FAIL %s acready: got %b want 0", nm, acready);
      end
      n = 0;
      while (crvalid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      tests++;
      if (n != lat) begin
         fails++;
         $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
      end
      tests++;
      if (crresp !== rsp) begin
         fails++;
         $display("FAIL %s crresp: got %h want %h", nm, crresp, rsp);
      end
      if (crready)
         tick();
   endtask

   task automatic clr_pulse();
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      tests++;
      if ({acready, crvalid, crresp, status_done, busy} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset outputs: got %b%b %h %b %b want 10 00 0 0",
                  acready, crvalid, crresp, status_done, busy);
      end
      tests++;
      if (hit_count !== 32'd0) begin
         fails++;
         $display("FAIL reset hit_count: got %h want 0", hit_count);
      end
   endtask

   task automatic test_disabled();
      cfg_en     = 1'b0;
      cfg_delay  = 32'd3;
      cfg_crresp = 5'h1F;
      snoop("disabled", 44'h0_0000_1000, 4'h0, 0, 5'h00, 1'b0);
      tests++;
      if (status_done !== 1'b0) begin
         fails++;
         $display("FAIL disabled done: got %b want 0", status_done);
      end
   endtask

   task automatic test_osh();
      cfg_en     = 1'b1;
      cfg_func   = 1'b0;
      cfg_delay  = 32'd2;
      cfg_crresp = 5'h1F;
      snoop("osh_first", 44'h0_0000_2000, 4'h3, 2, 5'h1F, 1'b0);
      tests++;
      if (status_done !== 1'b1 || hit_count !== 32'd1) begin
         fails++;
         $display("FAIL osh_status: got %b/%0d want 1/1", status_done, hit_count);
      end
      snoop("osh_second", 44'h0_0000_2000, 4'h3, 0, 5'h00, 1'b0);
      tests++;
      if (hit_count !== 32'd1) begin
         fails++;
         $display("FAIL osh_second hit: got %0d want 1", hit_count);
      end
      clr_pulse();
      tests++;
      if (status_done !== 1'b0 || hit_count !== 32'd0) begin
         fails++;
         $display("FAIL osh_clr: got %b/%0d want 0/0", status_done, hit_count);
      end
      snoop("osh_rearm", 44'h0_0000_2000, 4'h3, 2, 5'h1F, 1'b0);
   endtask

   task automatic test_addr_filter();
      clr_pulse();
      cfg_func    = 1'b1;
      cfg_addrflt = 1'b1;
      cfg_base    = 32'h10;
      cfg_size    = 32'h100;
      cfg_delay   = 32'd1;
      cfg_crresp  = 5'h0A;
      snoop("addr_below", 44'h0_0000_0000, 4'h0, 0, 5'h00, 1'b0);
      snoop("addr_base", 44'h0_0000_0010, 4'h0, 1, 5'h0A, 1'b0);
      snoop("addr_last", 44'h0_0000_010F, 4'h0, 1, 5'h0A, 1'b0);
      snoop("addr_end", 44'h0_0000_0110, 4'h0, 0, 5'h00, 1'b0);
      tests++;
      if (hit_count !== 32'd2) begin
         fails++;
         $display("FAIL addr_hits: got %0d want 2", hit_count);
      end
      snoop("addr_hibits", 44'hABC_0000_0020, 4'h0, 1, 5'h0A, 1'b0);
      tests++;
      if (hit_count !== 32'd3) begin
         fails++;
         $display("FAIL addr_hibits hit: got %0d want 3", hit_count);
      end
   endtask

   task automatic test_ac_filter();
      clr_pulse();
      cfg_acflt   = 1'b1;
      cfg_acsnoop = 4'h1;
      snoop("ac_match", 44'h0_0000_0020, 4'h1, 1, 5'h0A, 1'b0);
      snoop("ac_other", 44'h0_0000_0020, 4'hF, 0, 5'h00, 1'b0);
      snoop("ac_outside", 44'h0_0000_0200, 4'h1, 0, 5'h00, 1'b0);
      tests++;
      if (hit_count !== 32'd1) begin
         fails++;
         $display("FAIL ac_hits: got %0d want 1", hit_count);
      end
      cfg_acflt   = 1'b0;
      cfg_addrflt = 1'b0;
   endtask

   task automatic test_stall();
      bit bad;
      cfg_delay  = 32'd0;
      cfg_crresp = 5'h15;
      crready    = 1'b0;
      snoop("stall", 44'h0_0000_0040, 4'h2, 0, 5'h15, 1'b0);
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (crvalid !== 1'b1 || crresp !== 5'h15 || acready !== 1'b0)
            bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL stall hold: got %b/%h/%b want 1/15/0", crvalid, crresp, acready);
      end
      crready = 1'b1;
      tick();
      tests++;
      if (acready !== 1'b1 || crvalid !== 1'b0) begin
         fails++;
         $display("FAIL stall release: got %b/%b want 1/0", acready, crvalid);
      end
      cfg_delay  = 32'd3;
      cfg_crresp = 5'h07;
      snoop("drop_en", 44'h0_0000_0040, 4'h2, 3, 5'h07, 1'b1);
      cfg_en = 1'b1;
   endtask

   task automatic test_reset_delay();
      bit bad;
      cfg_delay  = 32'd5;
      cfg_crresp = 5'h11;
      acaddr     = 44'h0_0000_0080;
      acvalid    = 1'b1;
      tick();
      acvalid = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b1 || crvalid !== 1'b0) begin
         fails++;
         $display("FAIL rst_delay pre: got busy %b crvalid %b want 1/0", busy, crvalid);
      end
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tests++;
      if ({acready, crvalid, crresp, status_done, busy} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}
          || hit_count !== 32'd0) begin
         fails++;
         $display("FAIL rst_delay outputs: got %b%b %h %b %b %0d want 10 00 0 0 0",
                  acready, crvalid, crresp, status_done, busy, hit_count);
      end
      bad = 1'b0;
      repeat (8) begin
         tick();
         if (crvalid !== 1'b0)
            bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL rst_delay abandon: got crvalid 1 want 0");
      end
   endtask

   task automatic test_wrap();
      cfg_func    = 1'b1;
      cfg_addrflt = 1'b1;
      cfg_base    = 32'hFFFF_FFF0;
      cfg_size    = 32'h20;
      cfg_delay   = 32'd0;
      cfg_crresp  = 5'h1C;
      snoop("wrap_in", 44'h0_FFFF_FFF8, 4'h0, 0, 5'h1C, 1'b0);
      snoop("wrap_low", 44'h0_0000_0004, 4'h0, 0, 5'h00, 1'b0);
      cfg_addrflt = 1'b0;
   endtask

   task automatic test_clr_collision();
      cfg_crresp = 5'h03;
      snoop("coll_a", 44'h0_0000_0100, 4'h0, 0, 5'h03, 1'b0);
      snoop("coll_b", 44'h0_0000_0100, 4'h0, 0, 5'h03, 1'b0);
      crready = 1'b0;
      snoop("coll_c", 44'h0_0000_0100, 4'h0, 0, 5'h03, 1'b0);
      status_clr = 1'b1;
      crready    = 1'b1;
      tick();
      status_clr = 1'b0;
      tests++;
      if (status_done !== 1'b1 || hit_count !== 32'd1) begin
         fails++;
         $display("FAIL clr_collision: got %b/%0d want 1/1", status_done, hit_count);
      end
   endtask

   initial begin
      resetn      = 1'b0;
      cfg_en      = 1'b0;
      cfg_func    = 1'b0;
      cfg_acflt   = 1'b0;
      cfg_addrflt = 1'b0;
      cfg_acsnoop = 4'h0;
      cfg_base    = 32'h0;
      cfg_size    = 32'h0;
      cfg_delay   = 32'd0;
      cfg_crresp  = 5'h0;
      status_clr  = 1'b0;
      acvalid     = 1'b0;
      acaddr      = 44'h0;
      acsnoop     = 4'h0;
      crready     = 1'b1;
      test_reset();
      test_disabled();
      test_osh();
      test_addr_filter();
      test_ac_filter();
      test_stall();
      test_reset_delay();
      test_wrap();
      test_clr_collision();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/devil_snoop_sched.md
DEVIL_SNOOP_SCHED -- requirements
Module: devil_snoop_sched

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  single clock
- resetn  in  1  synchronous active-low reset
- cfg_en  in  1  attack enable
- cfg_func  in  1  0 = OSH (one-shot), 1 = CON (continuous)
- cfg_acflt  in  1  acsnoop filter enable
- cfg_addrflt  in  1  address filter enable
- cfg_acsnoop  in  4  acsnoop value to match
- cfg_base  in  32  filter base address
- cfg_size  in  32  filter window size in bytes
- cfg_delay  in  32  CR delay in cycles for attacked snoops
- cfg_crresp  in  5  crresp driven on attacked snoops
- status_clr  in  1  one-cycle pulse; clears status_done and hit_count
- acvalid  in  1  AC request valid
- acready  out  1  AC request accept
- acaddr  in  44  snoop address
- acsnoop  in  4  snoop type
- crvalid  out  1  CR response valid
- crready  in  1  CR response accept
- crresp  out  5  snoop response
- status_done  out  1  sticky: at least one attacked response completed
- hit_count  out  32  attacked responses completed, saturating
- busy  out  1  high in any state other than IDLE

Function
REQ-003 FSM states SHALL be IDLE, DELAY, RESP; acready = 1 only in IDLE; crvalid = 1 only in RESP.
REQ-004 AC handshake = acvalid & acready in IDLE; on it the block SHALL latch cfg_delay, cfg_crresp and the match decision; later config changes SHALL NOT affect the in-flight snoop.
REQ-005 Address match = (cfg_size != 0) & (cfg_base <= acaddr[31:0]) & (acaddr[31:0] < cfg_base + cfg_size), sum computed 33 bits wide (no wrap); acaddr[43:32] is ignored.
REQ-006 AC match = (acsnoop == cfg_acsnoop).
REQ-007 Match = (!cfg_addrflt | addr match) & (!cfg_acflt | AC match); with both filters off every snoop matches.
REQ-008 Attack = cfg_en & match & (cfg_func == CON | !status_done), all evaluated at the handshake cycle.
REQ-009 IDLE -> RESP on a non-attacked handshake, with crresp = 5'b0; crvalid SHALL rise in cycle T+1 for a handshake in cycle T.
REQ-010 IDLE -> DELAY on an attacked handshake with latched delay D > 0, loading a down-counter with D; the block SHALL go DELAY -> RESP when the counter reaches 1, so crvalid rises at T+1+D.
REQ-011 An attacked handshake with D = 0 SHALL go IDLE -> RESP directly (crvalid at T+1), with crresp = latched cfg_crresp.
REQ-012 RESP SHALL hold crvalid and crresp stable until crready; on the handshake the block SHALL return to IDLE, with acready = 1 in the next cycle.
REQ-013 Every accepted snoop SHALL receive exactly one CR response; deasserting cfg_en mid-DELAY or mid-RESP SHALL NOT abort the transaction.
REQ-014 On the CR handshake of an attacked snoop, status_done SHALL set and hit_count SHALL increment, saturating at 32'hFFFFFFFF.
REQ-015 status_clr SHALL clear status_done and hit_count; if it coincides with an attacked CR handshake, the set/increment SHALL win (status_done = 1, hit_count = 1).
REQ-016 In OSH mode, once status_done = 1 all further snoops SHALL be answered benignly until status_clr re-arms the block.
REQ-017 Only one snoop SHALL be outstanding; acready SHALL stay 0 from the handshake until return to IDLE.

Reset
REQ-018 With resetn = 0 at a clk edge, the block SHALL enter IDLE, with acready = 1, crvalid = 0, crresp = 0, status_done = 0, hit_count = 0, busy = 0 and the delay counter = 0.
REQ-019 Reset mid-DELAY or mid-RESP SHALL abandon the in-flight snoop without emitting crvalid.

Verification
REQ-020 cfg_en = 0, acvalid pulse at cycle T -> crvalid at T+1 with crresp = 0; status_done stays 0.
REQ-021 OSH, cfg_delay = 2, cfg_crresp = 5'h1F, no filters, crready tied 1 -> first snoop: crvalid at T+3 with crresp = 5'h1F, then status_done = 1; second snoop gets crresp = 0 at T'+1; status_clr re-arms the block.
REQ-022 CON, cfg_addrflt = 1, cfg_base = 32'h10, cfg_size = 32'h100:
- acaddr = 32'h0 -> benign
- acaddr = 32'h10 and 32'h10F -> attacked
- acaddr = 32'h110 -> benign
- final hit_count = 2
REQ-023 CON with cfg_acflt = 1, cfg_acsnoop = 4'h1, cfg_addrflt = 1: only snoops with acsnoop = 1 inside the window are attacked; acsnoop = 4'hF is answered benignly.
REQ-024 crready held 0 for 5 cycles in RESP -> crvalid and crresp stable and acready = 0 throughout; cfg_en dropped in DELAY -> the attacked response still completes with cfg_crresp.
REQ-025 resetn = 0 asserted in DELAY -> next cycle IDLE with all outputs at reset values; cfg_base = 32'hFFFFFFF0, cfg_size = 32'h20, acaddr = 32'hFFFFFFF8 -> attacked (no wrap false-miss).
